shift_unit_pipe: RTL and testbench
==================================

Name: shift_unit_pipe

Overview:
- Parametrised, two-stage pipelined barrel shifter for the RV64 ALU. Successor to the single-mode combinational logical-right shifter.
- Supports SLL, SRL and SRA, plus word variants (SLLW/SRLW/SRAW) that operate on the low half and sign-extend the result.
- Sits between the execute-stage operand latch and the writeback mux.
- Uses a valid/ready handshake with full-pipeline stall on backpressure.

Parameters:
- N, 64: datapath width. Power of two, N >= 8.
- SPLIT, $clog2(N)/2: number of mux levels (shift bits 0..SPLIT-1) resolved in stage 1. Remaining levels are resolved in stage 2.
- WORD_OPS, 1: enables the word variants. When 0, the word input is ignored and treated as 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_data  in  N  operand.
- in_shamt  in  $clog2(N)  shift amount.
- in_op  in  2  shift_op_t: 00=SLL, 01=SRL, 11=SRA, 10=reserved (treated as SLL).
- in_word  in  1  word variant.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  N  result.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_data=0, all stage registers 0. in_ready=1 combinationally while reset is deasserted and the pipe is empty. Reset mid-operation discards in-flight requests; no output appears for them.
- Advance enable: en = !out_valid || out_ready. Set in_ready = en.
  - A request is accepted on the rising edge when in_valid && in_ready.
  - When en=0, every stage holds its value. out_data and out_valid stay stable until the handshake completes.
- Latency: 2 cycles, accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- Stage 1, on en:
  - s1_valid <= in_valid.
  - Effective amount: amt = in_word ? {1'b0, in_shamt[$clog2(N)-2:0]} : in_shamt.
  - Word-mode operand preconditioning:
    - SRL: low N/2 bits zero-extended.
    - SRA: low N/2 bits sign-extended from bit N/2-1.
    - SLL: unchanged.
  - SRL/SRA are implemented as shift-right with fill = (op==SRA) ? operand MSB : 0.
  - SLL is implemented by bit-reversing the operand, shifting right with fill 0, and reversing back in stage 2.
  - Mux levels 0..SPLIT-1 are applied (level i shifts by 2^i). Partial result, fill bit, op, word flag and amt[high bits] are registered.
- Stage 2, on en:
  - out_valid <= s1_valid.
  - Remaining levels SPLIT..$clog2(N)-1 are applied with the registered fill.
  - Bit-reverse is undone for SLL.
  - If word: result = sign-extend of result[N/2-1:0] to N bits. out_data is registered.
- Shift by 0 returns the operand (word mode: sign-extended low half). Maximum shift N-1 (word N/2-1) is legal. The upper shamt bit is ignored in word mode.
- Simultaneous accept and output drain in the same cycle is legal and keeps full throughput.
- A bubble (in_valid=0 while en=1) propagates as s1_valid=0. out_valid falls after the drain.
- out_data holds its last value when out_valid=0. It is not cleared except by reset.

Decomposition:
- Package shift_pkg:
  - shift_op_t enum (SLL, SRL, SRA).
  - localparam functions: log2 width, word half-width.
  - bit_reverse function.
- Sub-module shift_right_levels:
  - Parameters N, LO, HI.
  - Combinational chain of 2:1 mux levels LO..HI-1 with an explicit fill input.
  - Instantiated once per stage.

Test Plan:
- N=64, SRL, data=0x8000_0000_0000_0001, shamt=63, out_ready=1 -> out_data=0x1 exactly 2 cycles after accept.
- SRA, data=0xF000_0000_0000_0000, shamt=4 -> 0xFF00_0000_0000_0000. SLL, data=1, shamt=63 -> 0x8000_0000_0000_0000.
- Word: SRAW data=0x0000_0000_8000_0000 shamt=1 -> 0xFFFF_FFFF_C000_0000. SLLW data=0x1 shamt=31 -> 0xFFFF_FFFF_8000_0000. SRLW data=0xFFFF_FFFF_8000_0000 shamt=33 (bit5 ignored) -> 0x0000_0000_4000_0000.
- Back-to-back stream of 8 requests, out_ready toggled 1,0,0,1,...:
  - No request is lost or duplicated, and order is preserved.
  - in_ready=0 exactly while out_valid && !out_ready.
  - out_data is stable during the stall.
- rst_n pulsed low asynchronously, mid-clock, with 2 requests in flight -> out_valid=0 and out_data=0 immediately. No stale results appear after release. The next request completes normally.
- Random sweep of 10k (op, word, shamt, data) against a reference model, for N=64/SPLIT=3 and N=32/SPLIT=2/WORD_OPS=0 -> zero mismatches.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared op encoding and width helpers for the pipelined barrel shifter
package shift_pkg;
  typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, SRA = 2'b11} shift_op_t;
  localparam int MAXW = 256;
  function automatic int log2w(input int n);
    return $clog2(n);
  endfunction
  function automatic int halfw(input int n);
    return n / 2;
  endfunction
  function automatic logic [MAXW-1:0] bit_reverse(input logic [MAXW-1:0] x);
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW; i++) r[i] = x[MAXW-1-i];
    return r;
  endfunction
endpackage

// File: rtl/shift_right_levels.sv
// shift_right_levels: 2:1 mux levels LO..HI-1 of a right shifter with explicit fill
module shift_right_levels #(
  parameter int N  = 64,
  parameter int LO = 0,
  parameter int HI = 3
) (
  input  logic [N-1:0]     d,
  input  logic [HI-LO-1:0] amt,
  input  logic             fill,
  output logic [N-1:0]     q
);
  logic [N-1:0] st [HI-LO+1];
  assign st[0] = d;
  for (genvar g = 0; g < HI - LO; g++) begin : g_lvl
    localparam int S = 1 << (g + LO);
    assign st[g+1] = amt[g] ? {{S{fill}}, st[g][N-1:S]} : st[g];
  end
  assign q = st[HI-LO];
endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage SLL/SRL/SRA barrel shifter with word variants and valid/ready
module shift_unit_pipe import shift_pkg::*; #(
  parameter int N        = 64,
  parameter int SPLIT    = log2w(N) / 2,
  parameter int WORD_OPS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_data,
  input  logic [log2w(N)-1:0] in_shamt,
  input  logic [1:0]          in_op,
  input  logic                in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_data
);
  localparam int L = log2w(N);
  localparam int H = halfw(N);
  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [MAXW-1:0] t;
    t = bit_reverse(MAXW'(v));
    return t[MAXW-1 -: N];
  endfunction
  shift_op_t op;
  logic en, word, sra, sll, s1_valid, s1_fill, s1_sll, s1_word;
  logic [L-1:0] amt;
  logic [L-SPLIT-1:0] s1_amt;
  logic [N-1:0] pre, x, y1, s1_data, y2, r, res;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign op = shift_op_t'(in_op);
  assign word = (WORD_OPS != 0) && in_word;
  assign sra = op == SRA;
  assign sll = !(op == SRL || sra);
  assign amt = word ? {1'b0, in_shamt[L-2:0]} : in_shamt;
  assign pre = (!word || sll) ? in_data : {{H{sra && in_data[H-1]}}, in_data[H-1:0]};
  // left shifts reuse the right-shift network on the mirrored operand
  assign x = sll ? rev(pre) : pre;
  shift_right_levels #(.N(N), .LO(0), .HI(SPLIT)) u_s1 (
    .d(x), .amt(amt[SPLIT-1:0]), .fill(sra && pre[N-1]), .q(y1)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_fill  <= 1'b0;
      s1_sll   <= 1'b0;
      s1_word  <= 1'b0;
      s1_amt   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_data  <= y1;
      s1_fill  <= sra && pre[N-1];
      s1_sll   <= sll;
      s1_word  <= word;
      s1_amt   <= amt[L-1:SPLIT];
    end
  shift_right_levels #(.N(N), .LO(SPLIT), .HI(L)) u_s2 (
    .d(s1_data), .amt(s1_amt), .fill(s1_fill), .q(y2)
  );
  assign r = s1_sll ? rev(y2) : y2;
  assign res = s1_word ? {{H{r[H-1]}}, r[H-1:0]} : r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_data  <= res;
    end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed, stall, reset and random checks of shift_unit_pipe against a behavioural model
module tb_shift_unit_pipe;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1, in_word = 0;
  logic [63:0] in_data = '0;
  logic [5:0] in_shamt = '0;
  logic [1:0] in_op = '0;
  logic in_ready, out_valid, in_ready32, out_valid32;
  logic [63:0] out_data;
  logic [31:0] out_data32;
  int checks = 0, errors = 0;

  shift_unit_pipe #(.N(64), .SPLIT(3), .WORD_OPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_word(in_word), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );
  shift_unit_pipe #(.N(32), .SPLIT(2), .WORD_OPS(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data[31:0]),
    .in_shamt(in_shamt[4:0]), .in_op(in_op), .in_word(in_word), .out_valid(out_valid32),
    .out_ready(out_ready), .out_data(out_data32)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model64(input logic [1:0] op, input logic w, input logic [5:0] sh, input logic [63:0] d);
    int s;
    logic [31:0] a, r32;
    logic [63:0] r;
    s = w ? int'(sh) % 32 : int'(sh);
    a = d[31:0];
    if (w) begin
      case (op)
        2'b01: r32 = a >> s;
        2'b11: r32 = $signed(a) >>> s;
        default: r32 = a << s;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        2'b01: r = d >> s;
        2'b11: r = $signed(d) >>> s;
        default: r = d << s;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] model32(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      2'b01: r = d >> sh;
      2'b11: r = $signed(d) >>> sh;
      default: r = d << sh;
    endcase
    return r;
  endfunction

  logic [63:0] t_data [6] = '{64'h8000_0000_0000_0001, 64'hF000_0000_0000_0000, 64'h1,
                              64'h0000_0000_8000_0000, 64'h1, 64'hFFFF_FFFF_8000_0000};
  logic [5:0]  t_sh   [6] = '{6'd63, 6'd4, 6'd63, 6'd1, 6'd31, 6'd33};
  logic [1:0]  t_op   [6] = '{2'b01, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01};
  logic        t_w    [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [63:0] t_exp  [6] = '{64'h1, 64'hFF00_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_4000_0000};

  task automatic test_reset();
    rst_n = 0;
    #2;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    if (out_data32 !== 32'h0) begin errors++; $display("FAIL reset_out_data32 got %h want 0", out_data32); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = t_data[i]; in_shamt = t_sh[i]; in_op = t_op[i]; in_word = t_w[i]; out_ready = 1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %0b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %0b want 0", i, out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got valid %0b want 1", i, out_valid); end
      if (out_data !== t_exp[i]) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, out_data, t_exp[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] held = '0;
    logic stall_prev = 0;
    int sent = 0, got = 0, cyc = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (got < 8 && cyc < 100) begin
      in_valid = sent < 8;
      in_data = {$urandom, $urandom}; in_shamt = 6'($urandom); in_op = 2'($urandom); in_word = 1'($urandom);
      out_ready = pat[cyc % 4];
      @(negedge clk);
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL b2b_in_ready cyc %0d got %0b want %0b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL b2b_stall_hold cyc %0d got %0b/%h want 1/%h", cyc, out_valid, out_data, held);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra_output got %h want none", out_data); end
        else begin
          logic [63:0] e = q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL b2b_order got %h want %h", out_data, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model64(in_op, in_word, in_shamt, in_data));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks += 2;
    if (got != 8 || q.size() != 0) begin errors++; $display("FAIL b2b_count got %0d left %0d want 8/0", got, q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_duplicate got valid %0b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    int wait_cyc = 0;
    out_ready = 0;
    in_valid = 1; in_data = 64'h1234_5678_9ABC_DEF0; in_shamt = 6'd8; in_op = 2'b01; in_word = 0;
    @(posedge clk); #1;
    in_data = 64'hDEAD_BEEF_0000_0001; in_shamt = 6'd3;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b want 0", out_valid); end
    if (out_data !== 64'h0) begin errors++; $display("FAIL mid_reset_data got %h want 0", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %0b want 1", in_ready); end
    @(negedge clk); #2;
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_stale cyc %0d got valid %0b want 0", i, out_valid); end
    end
    @(posedge clk); #1;
    in_valid = 1; in_data = 64'h00F0_0000_0000_0000; in_shamt = 6'd4; in_op = 2'b00; in_word = 0;
    e = model64(in_op, in_word, in_shamt, in_data);
    @(posedge clk); #1;
    in_valid = 0;
    while (!out_valid && wait_cyc < 5) begin @(posedge clk); #1; wait_cyc++; end
    checks += 2;
    if (wait_cyc != 1) begin errors++; $display("FAIL mid_reset_recover_latency got %0d want 1 extra cycle", wait_cyc); end
    if (out_data !== e) begin errors++; $display("FAIL mid_reset_recover_data got %h want %h", out_data, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n);
    logic [63:0] q64[$];
    logic [31:0] q32[$];
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 4 * n) begin
      in_valid = sent < n && $urandom_range(0, 7) != 0;
      in_data = {$urandom, $urandom};
      in_shamt = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) == 1 ? 6'd63 : 6'd0) : 6'($urandom);
      in_op = 2'($urandom); in_word = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks += 2;
        if (q64.size() == 0 || q32.size() == 0) begin errors++; $display("FAIL rnd_extra_output got %h want none", out_data); end
        else begin
          logic [63:0] e64 = q64.pop_front();
          logic [31:0] e32 = q32.pop_front();
          if (out_data !== e64) begin errors++; $display("FAIL rnd64 #%0d got %h want %h", got, out_data, e64); end
          if (out_valid32 !== 1'b1 || out_data32 !== e32) begin
            errors++; $display("FAIL rnd32 #%0d got %0b/%h want 1/%h", got, out_valid32, out_data32, e32);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q64.push_back(model64(in_op, in_word, in_shamt, in_data));
        q32.push_back(model32(in_op, in_shamt[4:0], in_data[31:0]));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    checks++;
    if (got != n) begin errors++; $display("FAIL rnd_timeout got %0d results want %0d", got, n); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
